// File: rtl/reg_alu_pkg.sv
// reg_alu_pkg: shared encodings for the reg_alu datapath and its instruction sequencer.
package reg_alu_pkg;
  localparam logic [1:0] OPC_LDI = 2'b00;
  localparam logic [1:0] OPC_ALU = 2'b01;
  localparam logic [1:0] OPC_RD  = 2'b10;
  localparam logic [1:0] OPC_NOP = 2'b11;
  localparam logic [1:0] ALU_AND  = 2'b00;
  localparam logic [1:0] ALU_OR   = 2'b01;
  localparam logic [1:0] ALU_NAND = 2'b10;
  localparam logic [1:0] ALU_NOR  = 2'b11;
  localparam int OPC_LSB = 14;
  localparam int RD_LSB  = 11;
  localparam int RA_LSB  = 8;
  localparam int RB_LSB  = 5;
  localparam int OP_LSB  = 3;
  localparam int IMM_LSB = 0;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_FLAG, S_RESP} state_t;
  function automatic logic [1:0] opc_of(input logic [15:0] w);
    return w[OPC_LSB +: 2];
  endfunction
endpackage

// File: rtl/reg_alu.sv
// reg_alu: 8x8 register file with logic ALU; cout registers the carry of d_out_a + d_out_b every cycle.
module reg_alu
  import reg_alu_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sel,
  input  logic            wr,
  input  logic [1:0]      op,
  input  logic [AW-1:0]   rd_addr_a,
  input  logic [AW-1:0]   rd_addr_b,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   d_in,
  output logic [DW-1:0]   d_out_a,
  output logic [DW-1:0]   d_out_b,
  output logic            cout
);
  logic [DW-1:0] regs [2**AW];
  logic [DW-1:0] res, sum;
  assign d_out_a = regs[rd_addr_a];
  assign d_out_b = regs[rd_addr_b];
  assign sum     = d_out_a + d_out_b;
  assign res     = op == ALU_AND  ? d_out_a & d_out_b :
                   op == ALU_OR   ? d_out_a | d_out_b :
                   op == ALU_NAND ? ~(d_out_a & d_out_b) : ~(d_out_a | d_out_b);
  // Register contents deliberately survive reset; only the carry flop is cleared.
  always_ff @(posedge clk)
    if (wr) regs[wr_addr] <= sel ? res : d_in;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cout <= 1'b0;
    else cout <= sum < d_out_a;
endmodule

// File: rtl/reg_alu_dec.sv
// reg_alu_dec: Moore decode of (state, IR) into the reg_alu control signals.
module reg_alu_dec
  import reg_alu_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  state_t          state,
  input  logic [15:0]     ir,
  output logic            ra_sel,
  output logic            ra_wr,
  output logic [1:0]      ra_op,
  output logic [AW-1:0]   ra_rd_addr_a,
  output logic [AW-1:0]   ra_rd_addr_b,
  output logic [AW-1:0]   ra_wr_addr,
  output logic [DW-1:0]   ra_d_in
);
  logic [1:0] opc;
  logic       exec;
  assign opc          = opc_of(ir);
  assign exec         = state == S_EXEC;
  assign ra_sel       = exec && opc == OPC_ALU;
  assign ra_wr        = exec && (opc == OPC_LDI || opc == OPC_ALU);
  assign ra_op        = ra_sel ? ir[OP_LSB +: 2] : '0;
  assign ra_rd_addr_a = exec && (opc == OPC_ALU || opc == OPC_RD) ? ir[RA_LSB +: AW] : '0;
  assign ra_rd_addr_b = ra_sel ? ir[RB_LSB +: AW] : '0;
  assign ra_wr_addr   = ra_wr ? ir[RD_LSB +: AW] : '0;
  assign ra_d_in      = exec && opc == OPC_LDI ? ir[IMM_LSB +: DW] : '0;
endmodule

// File: rtl/reg_alu_seq.sv
// reg_alu_seq: instruction sequencer driving reg_alu through a four-state Moore FSM.
module reg_alu_seq
  import reg_alu_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [15:0]     instr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_data,
  output logic            flag_c,
  output logic [7:0]      instr_cnt,
  output logic            ra_sel,
  output logic            ra_wr,
  output logic [1:0]      ra_op,
  output logic [AW-1:0]   ra_rd_addr_a,
  output logic [AW-1:0]   ra_rd_addr_b,
  output logic [AW-1:0]   ra_wr_addr,
  output logic [DW-1:0]   ra_d_in,
  input  logic [DW-1:0]   ra_d_out_a,
  input  logic            ra_cout
);
  state_t      state, next;
  logic [15:0] ir;
  logic [1:0]  opc;
  assign opc         = opc_of(ir);
  assign instr_ready = state == S_IDLE;
  assign rsp_valid   = state == S_RESP;
  always_comb begin
    next = state;
    case (state)
      S_IDLE:  next = instr_valid ? S_EXEC : S_IDLE;
      S_EXEC:  next = opc == OPC_ALU ? S_FLAG : opc == OPC_RD ? S_RESP : S_IDLE;
      S_FLAG:  next = S_IDLE;
      default: next = rsp_ready ? S_IDLE : S_RESP;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= S_IDLE;
      ir        <= '0;
      rsp_data  <= '0;
      flag_c    <= 1'b0;
      instr_cnt <= '0;
    end else begin
      state <= next;
      if (instr_ready && instr_valid) ir <= instr;
      if (state == S_EXEC && opc == OPC_RD) rsp_data <= ra_d_out_a;
      if (state == S_FLAG) flag_c <= ra_cout;
      if (state != S_IDLE && next == S_IDLE) instr_cnt <= instr_cnt + 8'd1;
    end
  reg_alu_dec #(.DW(DW), .AW(AW)) u_dec (
    .state(state),
    .ir(ir),
    .ra_sel(ra_sel),
    .ra_wr(ra_wr),
    .ra_op(ra_op),
    .ra_rd_addr_a(ra_rd_addr_a),
    .ra_rd_addr_b(ra_rd_addr_b),
    .ra_wr_addr(ra_wr_addr),
    .ra_d_in(ra_d_in)
  );
endmodule

// File: tb/tb_reg_alu_seq.sv
// tb_reg_alu_seq: reg_alu_seq driving a real reg_alu, checked against an instruction-level model.
module tb_reg_alu_seq;
  logic        clk = 0, reset = 0, instr_valid = 0, rsp_ready = 1;
  logic [15:0] instr = '0;
  logic        instr_ready, rsp_valid, flag_c, ra_sel, ra_wr, ra_cout;
  logic [7:0]  rsp_data, instr_cnt, ra_d_in, ra_d_out_a, d_out_b;
  logic [1:0]  ra_op;
  logic [2:0]  ra_rd_addr_a, ra_rd_addr_b, ra_wr_addr;
  int          checks = 0, fails = 0;
  logic [7:0]  mreg [8];
  logic [7:0]  mcnt = 0;
  logic        mflag = 0;

  reg_alu_seq dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .flag_c(flag_c), .instr_cnt(instr_cnt), .ra_sel(ra_sel), .ra_wr(ra_wr), .ra_op(ra_op),
    .ra_rd_addr_a(ra_rd_addr_a), .ra_rd_addr_b(ra_rd_addr_b), .ra_wr_addr(ra_wr_addr),
    .ra_d_in(ra_d_in), .ra_d_out_a(ra_d_out_a), .ra_cout(ra_cout)
  );
  reg_alu u_ra (
    .clk(clk), .reset(reset), .sel(ra_sel), .wr(ra_wr), .op(ra_op),
    .rd_addr_a(ra_rd_addr_a), .rd_addr_b(ra_rd_addr_b), .wr_addr(ra_wr_addr),
    .d_in(ra_d_in), .d_out_a(ra_d_out_a), .d_out_b(d_out_b), .cout(ra_cout)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
    return {2'b00, rd, 3'b000, imm};
  endfunction
  function automatic logic [15:0] alu(input logic [2:0] rd, ra, rb, input logic [1:0] op);
    return {2'b01, rd, ra, rb, op, 3'b000};
  endfunction
  function automatic logic [15:0] rdi(input logic [2:0] ra);
    return {2'b10, 3'b000, ra, 8'h00};
  endfunction

  task automatic step(input logic [15:0] w, output logic [7:0] exp);
    logic [7:0] a, b;
    exp = 8'h00;
    a = mreg[w[10:8]];
    b = mreg[w[7:5]];
    case (w[15:14])
      2'b00: mreg[w[13:11]] = w[7:0];
      2'b01: begin
        mflag = (int'(a) + int'(b)) > 255;
        case (w[4:3])
          2'b00: mreg[w[13:11]] = a & b;
          2'b01: mreg[w[13:11]] = a | b;
          2'b10: mreg[w[13:11]] = ~(a & b);
          default: mreg[w[13:11]] = ~(a | b);
        endcase
      end
      2'b10: exp = a;
      default: ;
    endcase
    mcnt = mcnt + 8'd1;
  endtask

  task automatic send(input logic [15:0] w);
    int n = 0;
    instr_valid = 1;
    instr = w;
    while (!instr_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin checks++; fails++; $display("FAIL send_timeout: instr_ready stuck at %b, want 1", instr_ready); end
    @(posedge clk); #1;
    instr_valid = 0;
    instr = 16'($urandom);
  endtask

  task automatic exec(input logic [15:0] w, output int lat, output int wrn, output logic [2:0] wa,
                      output logic [7:0] wd, output logic [7:0] rv, output bit got);
    send(w);
    lat = 1; wrn = 0; wa = 0; wd = 0; rv = 0; got = 0;
    while (!instr_ready && lat < 50) begin
      if (ra_wr) begin wrn++; wa = ra_wr_addr; wd = ra_d_in; end
      if (rsp_valid && rsp_ready) begin got = 1; rv = rsp_data; end
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 50) begin checks++; fails++; $display("FAIL exec_timeout: instr %h never retired", w); end
  endtask

  task automatic test_reset;
    #1;
    checks++; if ({rsp_valid, flag_c, ra_wr, ra_sel} !== 4'b0) begin fails++; $display("FAIL reset_bits: got %b want 0000", {rsp_valid, flag_c, ra_wr, ra_sel}); end
    checks++; if ({rsp_data, instr_cnt, ra_d_in} !== 24'h0) begin fails++; $display("FAIL reset_data: got %h want 000000", {rsp_data, instr_cnt, ra_d_in}); end
    checks++; if ({ra_op, ra_rd_addr_a, ra_rd_addr_b, ra_wr_addr} !== 11'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", {ra_op, ra_rd_addr_a, ra_rd_addr_b, ra_wr_addr}); end
    @(posedge clk); #1;
    reset = 1;
    #1;
    checks++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
  endtask

  task automatic test_ldi_rd;
    int lat, wrn; logic [2:0] wa; logic [7:0] wd, rv, e; bit got;
    step(ldi(1, 8'h3C), e); exec(ldi(1, 8'h3C), lat, wrn, wa, wd, rv, got);
    checks++; if (wrn !== 1 || wa !== 3'd1 || wd !== 8'h3C || lat !== 2) begin fails++; $display("FAIL ldi_r1: wr=%0d addr=%0d d=%h lat=%0d want 1 1 3c 2", wrn, wa, wd, lat); end
    step(ldi(2, 8'h0F), e); exec(ldi(2, 8'h0F), lat, wrn, wa, wd, rv, got);
    checks++; if (wrn !== 1 || wa !== 3'd2 || wd !== 8'h0F) begin fails++; $display("FAIL ldi_r2: wr=%0d addr=%0d d=%h want 1 2 0f", wrn, wa, wd); end
    step(rdi(1), e); exec(rdi(1), lat, wrn, wa, wd, rv, got);
    checks++; if (!got || rv !== 8'h3C || wrn !== 0) begin fails++; $display("FAIL rd_r1: got=%0d data=%h wr=%0d want 1 3c 0", got, rv, wrn); end
    checks++; if (instr_cnt !== 8'd3) begin fails++; $display("FAIL cnt3: got %0d want 3", instr_cnt); end
  endtask

  task automatic test_alu_ops;
    int lat, wrn; logic [2:0] wa; logic [7:0] wd, rv, e; bit got;
    logic [7:0] tbl [4] = '{8'h0C, 8'h3F, 8'hF3, 8'hC0};
    for (int op = 0; op < 4; op++) begin
      step(alu(3, 1, 2, 2'(op)), e); exec(alu(3, 1, 2, 2'(op)), lat, wrn, wa, wd, rv, got);
      checks++; if (lat !== 3 || wrn !== 1 || wa !== 3'd3 || flag_c !== mflag) begin fails++; $display("FAIL alu_op%0d: lat=%0d wr=%0d addr=%0d c=%b want 3 1 3 %b", op, lat, wrn, wa, flag_c, mflag); end
      step(rdi(3), e); exec(rdi(3), lat, wrn, wa, wd, rv, got);
      checks++; if (!got || rv !== tbl[op]) begin fails++; $display("FAIL alu_res%0d: got %h want %h", op, rv, tbl[op]); end
    end
  endtask

  task automatic test_rsp_stall;
    logic [7:0] e;
    logic [7:0] c0;
    rsp_ready = 0;
    step(rdi(2), e);
    send(rdi(2));
    c0 = instr_cnt;
    @(posedge clk); #1;
    instr_valid = 1;
    instr = 16'hC000;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h0F || instr_ready !== 1'b0 || instr_cnt !== c0) begin fails++; $display("FAIL stall%0d: v=%b d=%h rdy=%b cnt=%0d want 1 0f 0 %0d", i, rsp_valid, rsp_data, instr_ready, instr_cnt, c0); end
      @(posedge clk); #1;
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || instr_ready !== 1'b1 || instr_cnt !== mcnt) begin fails++; $display("FAIL stall_release: v=%b rdy=%b cnt=%0d want 0 1 %0d", rsp_valid, instr_ready, instr_cnt, mcnt); end
    step(16'hC000, e);
    @(posedge clk); #1;
    instr_valid = 0;
    checks++; if (instr_ready !== 1'b0) begin fails++; $display("FAIL stall_next_accept: rdy=%b want 0", instr_ready); end
    @(posedge clk); #1;
    checks++; if (instr_cnt !== mcnt) begin fails++; $display("FAIL stall_next_cnt: got %0d want %0d", instr_cnt, mcnt); end
  endtask

  task automatic test_random;
    int lat, wrn; logic [2:0] wa; logic [7:0] wd, rv, e; bit got;
    logic [15:0] w;
    for (int r = 0; r < 8; r++) begin
      w = ldi(3'(r), 8'($urandom)); step(w, e); exec(w, lat, wrn, wa, wd, rv, got);
    end
    for (int i = 0; i < 60; i++) begin
      w = 16'($urandom);
      step(w, e);
      exec(w, lat, wrn, wa, wd, rv, got);
      checks++; if (wrn !== int'(w[15:14] == 2'b00 || w[15:14] == 2'b01)) begin fails++; $display("FAIL rnd_wr %h: pulses %0d", w, wrn); end
      if (w[15:14] == 2'b10) begin
        checks++; if (!got || rv !== e) begin fails++; $display("FAIL rnd_rd %h: got %h want %h", w, rv, e); end
      end else begin
        checks++; if (lat !== (w[15:14] == 2'b01 ? 3 : 2)) begin fails++; $display("FAIL rnd_lat %h: got %0d", w, lat); end
      end
      checks++; if (instr_cnt !== mcnt || flag_c !== mflag) begin fails++; $display("FAIL rnd_state %h: cnt=%0d c=%b want %0d %b", w, instr_cnt, flag_c, mcnt, mflag); end
    end
  endtask

  task automatic test_back_to_back;
    int n, acc = 0, last = -1, bad = 0, wrs = 0, cyc = 0;
    n = 256 - int'(mcnt);
    instr_valid = 1;
    instr = {2'b11, 14'($urandom)};
    while (acc < n && cyc < 1000) begin
      if (ra_wr) wrs++;
      if (instr_ready) begin
        if (last >= 0 && cyc - last != 2) bad++;
        last = cyc;
        acc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    instr_valid = 0;
    @(posedge clk); #1;
    mcnt = mcnt + 8'(n);
    checks++; if (acc !== n) begin fails++; $display("FAIL b2b_accepts: got %0d want %0d", acc, n); end
    checks++; if (bad !== 0 || wrs !== 0) begin fails++; $display("FAIL b2b_spacing: bad gaps %0d wr pulses %0d want 0 0", bad, wrs); end
    checks++; if (instr_cnt !== 8'h00) begin fails++; $display("FAIL b2b_wrap: got %h want 00", instr_cnt); end
  endtask

  task automatic test_reset_mid_ldi;
    int lat, wrn; logic [2:0] wa; logic [7:0] wd, rv, e; bit got;
    step(ldi(4, 8'h55), e); exec(ldi(4, 8'h55), lat, wrn, wa, wd, rv, got);
    send(ldi(4, 8'hAA));
    checks++; if (ra_wr !== 1'b1) begin fails++; $display("FAIL mid_exec_wr: got %b want 1", ra_wr); end
    reset = 0;
    #1;
    checks++; if ({ra_wr, ra_sel, ra_d_in, ra_wr_addr, instr_cnt, rsp_data} !== 29'h0 || instr_ready !== 1'b1) begin fails++; $display("FAIL mid_reset_out: wr=%b d=%h a=%0d cnt=%0d rdy=%b want 0 00 0 0 1", ra_wr, ra_d_in, ra_wr_addr, instr_cnt, instr_ready); end
    @(posedge clk); #1;
    reset = 1;
    mcnt = 0; mflag = 0;
    step(rdi(4), e); exec(rdi(4), lat, wrn, wa, wd, rv, got);
    checks++; if (!got || rv !== e || rv !== 8'h55) begin fails++; $display("FAIL mid_reset_r4: got %h want 55", rv); end
  endtask

  task automatic test_reset_resp;
    int lat, wrn; logic [2:0] wa; logic [7:0] wd, rv, e; bit got;
    step(ldi(5, 8'hF0), e); exec(ldi(5, 8'hF0), lat, wrn, wa, wd, rv, got);
    step(ldi(6, 8'h20), e); exec(ldi(6, 8'h20), lat, wrn, wa, wd, rv, got);
    step(alu(7, 5, 6, 2'b00), e); exec(alu(7, 5, 6, 2'b00), lat, wrn, wa, wd, rv, got);
    checks++; if (flag_c !== mflag || flag_c !== 1'b1) begin fails++; $display("FAIL carry_set: got %b want 1", flag_c); end
    rsp_ready = 0;
    send(rdi(5));
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hF0) begin fails++; $display("FAIL resp_pending: v=%b d=%h want 1 f0", rsp_valid, rsp_data); end
    #2 reset = 0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || flag_c !== 1'b0) begin fails++; $display("FAIL resp_async: v=%b d=%h c=%b want 0 00 0", rsp_valid, rsp_data, flag_c); end
    @(posedge clk); #1;
    reset = 1;
    rsp_ready = 1;
    @(posedge clk); #1;
    checks++; if (instr_ready !== 1'b1 || rsp_valid !== 1'b0 || flag_c !== 1'b0 || instr_cnt !== 8'h00) begin fails++; $display("FAIL resp_after: rdy=%b v=%b c=%b cnt=%0d want 1 0 0 0", instr_ready, rsp_valid, flag_c, instr_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    test_reset;
    test_ldi_rd;
    test_alu_ops;
    test_rsp_stall;
    test_random;
    test_back_to_back;
    test_reset_mid_ldi;
    test_reset_resp;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
